// File: rtl/risc_pkg.sv
// Shared KGP-RISC definitions: instruction width, opcode encodings, fetch buffer entry.
package risc_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_IMM    = 4'b0001;
    localparam logic [3:0] OP_LDST   = 4'b0010;
    localparam logic [3:0] OP_BR_REG = 4'b0011;
    localparam logic [3:0] OP_BR     = 4'b0100;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} between instruction memory and decoder.
// Flush wins over push; the caller guarantees no push when full.
import risc_pkg::*;

module fetch_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// KGP-RISC fetch stage: PC, synchronous imem read, 2-entry output buffer, redirect flush.
// Optional halt-word detection is enabled by defining IFU_HALT_DETECT_EN.
import risc_pkg::*;

module instruction_fetch_unit #(
    parameter int unsigned IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               halted
);

    logic [31:0]  pc_q;
    logic [31:0]  issued_pc_q;
    logic         inflight_q;
    logic         kill_q;
    logic         pop;
    logic         push;
    logic         issue;
    logic         stop_issue;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t resp;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !kill_q;
    assign resp        = '{instr: imem_rdata, pc: issued_pc_q};

    // Buffered words plus the read in flight, less what leaves this cycle, must leave a free slot.
    assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = !rst && !stop_issue && !redirect_valid && (occupancy < 3'd2);

    assign imem_en   = issue;
    assign imem_addr = pc_q[IMEM_AW+1:2];

`ifdef IFU_HALT_DETECT_EN
    logic halted_q;
    logic halt_hit;

    assign halt_hit = push && (imem_rdata == HALT_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
        end
    end

    // Stop in the push cycle too, so nothing past the halt word is fetched.
    assign stop_issue = halted_q || halt_hit;
    assign halted     = halted_q;
`else
    assign stop_issue = 1'b0;
    assign halted     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= 32'h0;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            // Redirect blocks issue, so this is normally 0; a response landing in the
            // redirect cycle itself is removed by the buffer flush.
            kill_q     <= redirect_valid && issue;
            if (issue) begin
                issued_pc_q <= pc_q;
                pc_q        <= pc_q + 32'd4;
            end
            if (redirect_valid) begin
                pc_q <= align_pc(redirect_pc);
            end
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (resp),
        .rdata (head),
        .count (count)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (IMEM_AW = 10, RESET_PC = 0).
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] last_hs_pc = 32'hFFFF_FFFF;
    logic        got_hs = 1'b0;
    logic        halt_plant = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_word;
    logic        found;

    instruction_fetch_unit #(
        .IMEM_AW  (10),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        if (halt_plant && a == 10'd4) return 32'hFFFF_FFFF;
        return 32'h1000_0000 + {22'b0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample at the falling edge.
    task automatic run(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        got_hs = 1'b0;
        if (instr_valid && instr_ready) begin
            check("hs_pc", instr_pc, exp_pc);
            check("hs_word", instr, mem_word(exp_pc[11:2]));
            last_hs_pc = instr_pc;
            exp_pc     = exp_pc + 32'd4;
            got_hs     = 1'b1;
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_en", imem_en, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_halted", halted, 0);

        // Cycle 0 issues, word 0 valid in cycle 2, then one per cycle.
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        check("c0_imem_en", imem_en, 1);
        check("c0_valid", instr_valid, 0);
        run(1, 0, 0);
        check("c1_valid", instr_valid, 0);
        check("c1_imem_addr", imem_addr, 1);
        run(1, 0, 0);
        check("c2_valid", instr_valid, 1);
        repeat (4) run(1, 0, 0);
        check("stream_last_pc", last_hs_pc, 32'h10);

        // Decoder stall: outputs hold, no issue, nothing lost afterwards.
        run(0, 0, 0);
        held_pc   = instr_pc;
        held_word = instr;
        check("stall_imem_en", imem_en, 0);
        repeat (5) begin
            run(0, 0, 0);
            check("stall_pc", instr_pc, held_pc);
            check("stall_word", instr, held_word);
            check("stall_valid", instr_valid, 1);
            check("stall_imem_en", imem_en, 0);
        end
        repeat (6) run(1, 0, 0);
        check("release_last_pc", last_hs_pc, held_pc + 32'd20);

        // Redirect with a read in flight: target word valid three cycles later.
        run(1, 1, 32'h0000_0103);
        run(1, 0, 0);
        check("redir_t1_valid", instr_valid, 0);
        check("redir_t1_en", imem_en, 1);
        check("redir_t1_addr", imem_addr, 10'h040);
        run(1, 0, 0);
        check("redir_t2_valid", instr_valid, 0);
        run(1, 0, 0);
        check("redir_t3_valid", instr_valid, 1);
        check("redir_t3_pc", last_hs_pc, 32'h100);

        // Redirect with buffer full and a handshake in the same cycle.
        run(0, 0, 0);
        run(0, 0, 0);
        held_pc = instr_pc;
        run(1, 1, 32'h0000_0200);
        check("full_redir_consumed", last_hs_pc, held_pc);
        run(1, 0, 0);
        check("full_redir_t1_valid", instr_valid, 0);
        run(1, 0, 0);
        check("full_redir_t2_valid", instr_valid, 0);
        run(1, 0, 0);
        check("full_redir_t3_pc", last_hs_pc, 32'h200);

        // Asynchronous reset mid-stream.
        repeat (2) run(1, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", instr_valid, 0);
        check("midrst_imem_en", imem_en, 0);
        check("midrst_instr_pc", instr_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = 32'h0;
        @(negedge clk);
        check("midrst_c0_addr", imem_addr, 0);
        run(1, 0, 0);
        run(1, 0, 0);
        check("midrst_restart_pc", last_hs_pc, 32'h0);

        // Memory address wraps while the PC keeps counting.
        run(1, 1, 32'h0000_0FF8);
        run(1, 0, 0);
        check("wrap_addr_t1", imem_addr, 10'h3FE);
        run(1, 0, 0);
        check("wrap_addr_t2", imem_addr, 10'h3FF);
        run(1, 0, 0);
        check("wrap_addr_t3", imem_addr, 10'h000);
        check("wrap_en_t3", imem_en, 1);
        repeat (3) run(1, 0, 0);
        check("wrap_pc", last_hs_pc, 32'h1004);

        // All-ones word at 0x10.
        halt_plant = 1'b1;
        run(1, 1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run(1, 0, 0);
            if (got_hs && last_hs_pc == 32'h10) found = 1'b1;
        end
        check("halt_word_delivered", found, 1);
`ifdef IFU_HALT_DETECT_EN
        check("halt_set", halted, 1);
        check("halt_no_issue", imem_en, 0);
        repeat (3) run(1, 0, 0);
        check("halt_drained", instr_valid, 0);
        check("halt_still_no_issue", imem_en, 0);
        check("halt_held", halted, 1);
        halt_plant = 1'b0;
        run(1, 1, 32'h40);
        run(1, 0, 0);
        check("halt_cleared", halted, 0);
        check("halt_resume_en", imem_en, 1);
        run(1, 0, 0);
        run(1, 0, 0);
        check("halt_resume_pc", last_hs_pc, 32'h40);
`else
        check("nohalt_halted", halted, 0);
        repeat (3) run(1, 0, 0);
        check("nohalt_still_0", halted, 0);
        check("nohalt_continues", last_hs_pc, 32'h1C);
        halt_plant = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the KGP-RISC pipeline: owns the program counter, reads 32-bit instruction words from a synchronous single-port instruction memory, and presents them with their PC to the instruction decoder over a valid/ready handshake. A 2-entry output buffer absorbs the one-cycle memory read latency so decoder stalls never lose a fetched word. The branch unit redirects the PC; a redirect flushes all fetched-but-unconsumed work.

## Interface
- `IMEM_AW`, 10: instruction-memory word-address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_en`  out  1  read strobe to instruction memory.
- `imem_addr`  out  IMEM_AW  word address, equals `pc[IMEM_AW+1:2]`.
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`.
- `redirect_valid`  in  1  branch taken / jump; load new PC.
- `redirect_pc`  in  32  target byte address; bits [1:0] ignored (forced 0).
- `instr_valid`  out  1  `instr` and `instr_pc` hold a word for the decoder.
- `instr_ready`  in  1  decoder accepts this cycle.
- `instr`  out  32  instruction word (opcode in [31:28]).
- `instr_pc`  out  32  byte address of `instr`.
- `halted`  out  1  fetch stopped on halt word (see Configuration).

## Operation
- State: `pc` (32 b), `inflight` (1 b, read issued last cycle), `kill` (1 b, drop in-flight response), 2-entry FIFO of {instr, pc}, `count` 0..2.
- Issue rule: `imem_en = !rst_state && !halted && !redirect_valid && (count + inflight - pop) < 2`, where `pop = instr_valid && instr_ready`. On issue, `pc <= pc + 4` (mod 2^32; memory address wraps at 2^IMEM_AW words).
- Response: cycle after issue, `{imem_rdata, issued pc}` pushes into FIFO unless `kill` set; `kill` clears after that cycle.
- Handshake: word transfers when `instr_valid && instr_ready`; `instr`/`instr_pc` hold stable while `instr_valid && !instr_ready`. `instr_valid` = `count != 0`.
- Redirect (any cycle): `pc <= {redirect_pc[31:2],2'b00}`, FIFO flushed (`count <= 0`), `kill <= inflight_from_this_cycle`, no issue this cycle. A handshake completing in the same cycle counts as consumed; the flush still applies to remaining entries.
- Full: `count == 2` with no pop -> no issue; inflight never exceeds free space, so FIFO never overflows.

## Timing
- Reset values: `pc = RESET_PC`, `imem_en = 0`, `imem_addr = RESET_PC[IMEM_AW+1:2]`, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`, `halted = 0`, `count = 0`, `inflight = kill = 0`.
- First issue in the first cycle after `rst` deasserts (cycle 0); first `instr_valid` in cycle 2.
- Fetch latency: issue at cycle t -> `instr_valid` at t+2 (no rdata bypass to outputs).
- Redirect at cycle t -> target issued at t+1 -> target word valid at t+3.
- Throughput: 1 word/cycle with `instr_ready` held high.
- `rst` asserted mid-operation: all state returns to reset values immediately; in-flight read discarded.

## Configuration
- `IFU_HALT_DETECT_EN` defined: when a pushed word equals 32'hFFFF_FFFF, the word is still delivered, `halted` sets the cycle after push, no further issue; cleared only by redirect or reset.
- Not defined: `halted` tied 0; 32'hFFFF_FFFF is an ordinary word (decoder treats it as invalid opcode).

## Structure
- Shared package `risc_pkg`: `INSTR_W = 32`, opcode constants `OP_RTYPE 4'b0000`, `OP_IMM 4'b0001`, `OP_LDST 4'b0010`, `OP_BR_REG 4'b0011`, `OP_BR 4'b0100`, `HALT_WORD 32'hFFFF_FFFF`.
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO {instr, pc} with push, pop, flush, count; flush has priority over push.

## Test plan
- Reset release, memory word i = 32'h1000_0000 + i, `instr_ready` = 1 -> `instr_valid` from cycle 2, `instr_pc` 0,4,8,... one per cycle, words in order.
- `instr_ready` low cycles 3-8 -> `instr`/`instr_pc` stable, `imem_en` low once count+inflight = 2, no word lost or duplicated after release.
- Redirect to 32'h0000_0103 at cycle 5 with a read in flight -> in-flight and buffered words dropped, next delivered `instr_pc` = 32'h0000_0100 at cycle 8.
- Redirect coinciding with a completed handshake and `count = 2` -> consumed word counted once, second entry flushed.
- `IMEM_AW = 4`, PC runs past 32'h3C -> `imem_addr` wraps to 0, `instr_pc` continues 32'h40.
- With `IFU_HALT_DETECT_EN`, word at 32'h10 = 32'hFFFF_FFFF -> word delivered, `halted` = 1, no `imem_en`; redirect to 0 clears `halted` and fetch resumes.
